booth_mult_pipe: RTL
====================

Name: booth_mult_pipe

Overview:
- Parametrised, pipelined radix-4 Booth multiplier with signed/unsigned select and multiply-accumulate/subtract modes.
- Successor to the fixed 32-bit begin/end multiplier used by the ALU/HI-LO path.
- Accepts one operation per cycle through a valid/ready handshake, with 3-cycle latency and full backpressure.
- Instantiated in the execute stage; feeds HI/LO writeback.

Parameters:
WIDTH, 32, operand width in bits; even, 8..64
ACC_EN, 1, 1 = MADD/MSUB supported; 0 = acc_in ignored and op_mode treated as MUL

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of all in-flight operations
in_valid  in  1  operation offered
in_ready  out  1  operation accepted when in_valid & in_ready
op_a  in  WIDTH  multiplicand
op_b  in  WIDTH  multiplier (Booth-recoded)
op_signed  in  1  1 = both operands two's complement; 0 = both unsigned
op_mode  in  2  00 MUL, 01 MADD (acc+p), 10 MSUB (acc-p), 11 reserved (treated as MUL)
acc_in  in  2*WIDTH  accumulator value, sampled with the operation
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
product  out  2*WIDTH  result, modulo 2^(2*WIDTH)

Behaviour:
- Reset (resetn low, asynchronous): all stage valid bits are 0, all data registers are 0, product = 0, out_valid = 0. in_ready is combinational and equals 1 after reset.
- Pipeline: S1 -> S2 -> S3. A stage loads when it is empty or when its contents move forward in the same cycle.
  - in_ready = !v1 | ld2
  - ld2 = v1 & (!v2 | ld3)
  - ld3 = v2 & (!v3 | out_ready)
  - out_valid = v3
- Latency: an operation accepted in cycle T produces out_valid in cycle T+3 when out_ready is held high. Throughput is 1 per cycle.
- Operand extension:
  - A_ext = 2*WIDTH-bit extension of op_a: sign-extended if op_signed, else zero-extended.
  - B_ext = {ext2, op_b, 1'b0}, where ext2 is 2 copies of op_b[MSB] if signed, else 2'b00.
- Booth recoding: NPP = WIDTH/2+1 digits. Digit i uses B_ext[2i+2:2i] and selects:
  - 000/111 -> 0
  - 001/010 -> +A
  - 011 -> +2A
  - 100 -> -2A
  - 101/110 -> -A
  - Negation is ~x+1 on 2*WIDTH bits. Partial product i is shifted left 2i and truncated to 2*WIDTH.
- S1 (register stage): NPP partial products, mode, acc_in.
- S2: carry-save reduction of the NPP partial products to sum/carry vectors, each 2*WIDTH bits (carries out of the MSB discarded), plus mode and acc.
- S3: p = sum+carry, then:
  - MUL -> p
  - MADD -> acc+p
  - MSUB -> acc-p
  - All results are modulo 2^(2*WIDTH). The result is registered into product.
- product holds its value while out_valid & !out_ready. product is unchanged when S3 empties; only the valid bit clears.
- flush: clears v1, v2 and v3 on the next edge; data registers are don't-care.
  - Any input offered in the same cycle as flush is dropped, even though in_ready may read 1.
  - flush has priority over all loads.
- Simultaneous accept and drain with the pipe full: legal; no bubble is inserted.
- With ACC_EN=0, op_mode is forced to MUL at S1 capture and the acc registers may be optimised away.
- Asserting resetn low mid-operation discards all in-flight ops immediately.
- Boundary corner cases, which must match the exact mathematical result mod 2^(2W):
  - unsigned 0xFFFF_FFFF squared
  - signed 0x8000_0000 × 0x8000_0000
  - top digit on an unsigned MSB=1 operand, which requires the 2-bit zero extension

Decomposition:
- Package booth_mult_pkg holds:
  - the op_mode encodings: MODE_MUL=2'b00, MODE_MADD=2'b01, MODE_MSUB=2'b10
  - a function for the Booth digit select encoding
- Sub-module booth_pp_sel (combinational): inputs are a 3-bit window and A_ext; output is one 2*WIDTH partial product. It is instantiated NPP times via generate.
- The CSA reduction is a generate loop of 3:2 compressors inside the top module; no separate module is needed.

Test Plan:
1. WIDTH=32, unsigned, MUL: 0xFFFFFFFF × 0xFFFFFFFF -> product 0xFFFFFFFE_00000001, out_valid 3 cycles after acceptance.
2. Signed MUL: 0x80000000 × 0x80000000 -> 0x40000000_00000000; then -3 × 7 -> 0xFFFFFFFF_FFFFFFEB.
3. MADD: acc=0x00000001_00000000, 0x10 × 0x10 signed -> 0x00000001_00000100. MSUB: acc=0, 2×3 -> 0xFFFFFFFF_FFFFFFFA.
4. Back-to-back stream of 8 ops, with out_ready low for cycles 4-6:
   - in_ready drops once the 3 stages are full.
   - No result is lost or duplicated; results arrive in issue order.
   - product is stable while stalled.
5. flush with 3 ops in flight plus 1 offered in the same cycle -> no out_valid afterwards; the next op accepted afterwards returns the correct result at latency 3.
6. resetn pulsed low asynchronously mid-stream, between clock edges -> out_valid and product are 0 immediately. WIDTH=8 build: random signed/unsigned sweep against a reference model, 10k vectors.

Source files
------------

// File: rtl/booth_mult_pkg.sv
// Shared definitions for the pipelined radix-4 Booth multiplier:
// operation mode encodings and the Booth digit decode.
package booth_mult_pkg;

   localparam logic [1:0] MODE_MUL  = 2'b00;
   localparam logic [1:0] MODE_MADD = 2'b01;
   localparam logic [1:0] MODE_MSUB = 2'b10;

   typedef enum logic [2:0] {
      SEL_ZERO = 3'd0,
      SEL_POS1 = 3'd1,
      SEL_POS2 = 3'd2,
      SEL_NEG1 = 3'd3,
      SEL_NEG2 = 3'd4
   } booth_sel_e;

   // Radix-4 recoding of one overlapping 3-bit multiplier window.
   function automatic booth_sel_e booth_sel(input logic [2:0] win);
      booth_sel_e sel;
      case (win)
         3'b001, 3'b010: sel = SEL_POS1;
         3'b011:         sel = SEL_POS2;
         3'b100:         sel = SEL_NEG2;
         3'b101, 3'b110: sel = SEL_NEG1;
         default:        sel = SEL_ZERO;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/booth_mult_pipe_pp_sel.sv
// One Booth partial-product selector: picks 0, +A, +2A, -A or -2A of the
// extended multiplicand according to a 3-bit multiplier window.
module booth_pp_sel
   import booth_mult_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]         win,
   input  logic [2*WIDTH-1:0] a_ext,
   output logic [2*WIDTH-1:0] pp
);

   localparam int W2 = 2 * WIDTH;
   localparam logic [W2-1:0] ONE = {{(W2-1){1'b0}}, 1'b1};

   logic [W2-1:0] a2_s;

   assign a2_s = a_ext << 1;

   // Digit select; negation is two's complement over the full product width.
   always_comb begin
      pp = {W2{1'b0}};
      case (booth_sel(win))
         SEL_POS1: pp = a_ext;
         SEL_POS2: pp = a2_s;
         SEL_NEG1: pp = ~a_ext + ONE;
         SEL_NEG2: pp = ~a2_s + ONE;
         default:  pp = {W2{1'b0}};
      endcase
   end

endmodule

// File: rtl/booth_mult_pipe.sv
// Three-stage radix-4 Booth multiplier with signed/unsigned operands,
// MUL/MADD/MSUB modes, valid/ready handshake and full backpressure.
module booth_mult_pipe
   import booth_mult_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter bit ACC_EN = 1'b1
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     op_a,
   input  logic [WIDTH-1:0]     op_b,
   input  logic                 op_signed,
   input  logic [1:0]           op_mode,
   input  logic [2*WIDTH-1:0]   acc_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product
);

   localparam int W2  = 2 * WIDTH;
   localparam int NPP = WIDTH / 2 + 1;

   logic              v1_r, v2_r, v3_r;
   logic              accept_s, ld2_s, ld3_s;
   logic [W2-1:0]     a_ext_s;
   logic [WIDTH+2:0]  b_ext_s;
   logic [1:0]        mode_sel_s;
   logic [W2-1:0]     acc_sel_s;
   logic [W2-1:0]     pp_sel_s [NPP];
   logic [W2-1:0]     pp_r [NPP];
   logic [1:0]        mode1_r, mode2_r;
   logic [W2-1:0]     acc1_r, acc2_r;
   logic [W2-1:0]     sum_red_s, carry_red_s;
   logic [W2-1:0]     sum2_r, carry2_r;
   logic [W2-1:0]     p_s, result_s, product_r;

   assign ld3_s     = v2_r & (~v3_r | out_ready);
   assign ld2_s     = v1_r & (~v2_r | ld3_s);
   assign in_ready  = ~v1_r | ld2_s;
   // An operation offered alongside flush is dropped even if in_ready is high.
   assign accept_s  = in_valid & in_ready & ~flush;
   assign out_valid = v3_r;
   assign product   = product_r;

   assign a_ext_s    = {{WIDTH{op_signed & op_a[WIDTH-1]}}, op_a};
   assign b_ext_s    = {{2{op_signed & op_b[WIDTH-1]}}, op_b, 1'b0};
   assign mode_sel_s = ACC_EN ? op_mode : MODE_MUL;
   assign acc_sel_s  = ACC_EN ? acc_in : {W2{1'b0}};

   for (genvar i = 0; i < NPP; i++) begin : g_pp
      logic [W2-1:0] raw_s;
      booth_pp_sel #(.WIDTH(WIDTH)) u_sel (
         .win   (b_ext_s[2*i+2 -: 3]),
         .a_ext (a_ext_s),
         .pp    (raw_s)
      );
      assign pp_sel_s[i] = raw_s << (2 * i);
   end

   // Linear chain of 3:2 compressors; carries out of the MSB are discarded.
   for (genvar i = 2; i < NPP; i++) begin : g_csa
      logic [W2-1:0] x_s, y_s, maj_s, sum_s, carry_s;
      if (i == 2) begin : g_first
         assign x_s = pp_r[0];
         assign y_s = pp_r[1];
      end else begin : g_next
         assign x_s = g_csa[i-1].sum_s;
         assign y_s = g_csa[i-1].carry_s;
      end
      assign sum_s   = x_s ^ y_s ^ pp_r[i];
      assign maj_s   = (x_s & y_s) | (x_s & pp_r[i]) | (y_s & pp_r[i]);
      assign carry_s = maj_s << 1;
   end

   assign sum_red_s   = g_csa[NPP-1].sum_s;
   assign carry_red_s = g_csa[NPP-1].carry_s;
   assign p_s         = sum2_r + carry2_r;

   // Final accumulate step; reserved mode behaves as plain multiply.
   always_comb begin
      result_s = p_s;
      case (mode2_r)
         MODE_MADD: result_s = acc2_r + p_s;
         MODE_MSUB: result_s = acc2_r - p_s;
         default:   result_s = p_s;
      endcase
   end

   // Stage valid bits; flush wins over every load.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         v1_r <= 1'b0;
         v2_r <= 1'b0;
         v3_r <= 1'b0;
      end else if (flush) begin
         v1_r <= 1'b0;
         v2_r <= 1'b0;
         v3_r <= 1'b0;
      end else begin
         v1_r <= accept_s | (v1_r & ~ld2_s);
         v2_r <= ld2_s | (v2_r & ~ld3_s);
         v3_r <= ld3_s | (v3_r & ~out_ready);
      end
   end

   // S1: partial products, mode and accumulator.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NPP; i++) pp_r[i] <= {W2{1'b0}};
         mode1_r <= MODE_MUL;
         acc1_r  <= {W2{1'b0}};
      end else if (accept_s) begin
         for (int i = 0; i < NPP; i++) pp_r[i] <= pp_sel_s[i];
         mode1_r <= mode_sel_s;
         acc1_r  <= acc_sel_s;
      end
   end

   // S2: carry-save sum/carry pair.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sum2_r   <= {W2{1'b0}};
         carry2_r <= {W2{1'b0}};
         mode2_r  <= MODE_MUL;
         acc2_r   <= {W2{1'b0}};
      end else if (ld2_s && !flush) begin
         sum2_r   <= sum_red_s;
         carry2_r <= carry_red_s;
         mode2_r  <= mode1_r;
         acc2_r   <= acc1_r;
      end
   end

   // S3: result register, held while stalled and after the stage empties.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         product_r <= {W2{1'b0}};
      end else if (ld3_s && !flush) begin
         product_r <= result_s;
      end
   end

endmodule
